// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 key tracker: make/break/extended decoding, typematic
// suppression, BCD press counter and registered seven-segment drive.
module ps2_key_tracker #(
    parameter int COUNT_DIGITS   = 2,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter bit SEG_ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    output logic                      key_held,
    output logic                      key_ext,
    output logic [7:0]                key_code,
    output logic [7:0]                key_ascii,
    output logic [4*COUNT_DIGITS-1:0] press_count,
    output logic [15:0]               seg_code,
    output logic [15:0]               seg_ascii,
    output logic [8*COUNT_DIGITS-1:0] seg_count
);

    localparam int CW = 4 * COUNT_DIGITS;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] POL = SEG_ACTIVE_LOW ? 8'h00 : 8'hff;
    localparam logic [7:0] BLANK = 8'hff ^ POL;

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    state_t        state;
    logic [TW-1:0] timer;

    logic brk_state;
    logic ext_state;
    logic same_key;
    logic make_now;
    logic release_now;

    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        logic [7:0] s;
        unique case (n)
            4'h0: s = 8'hc0;
            4'h1: s = 8'hf9;
            4'h2: s = 8'ha4;
            4'h3: s = 8'hb0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hf8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'ha: s = 8'h88;
            4'hb: s = 8'h83;
            4'hc: s = 8'hc6;
            4'hd: s = 8'ha1;
            4'he: s = 8'h86;
            4'hf: s = 8'h8e;
        endcase
        return s ^ POL;
    endfunction

    function automatic logic [7:0] ascii_of(input logic [7:0] c);
        logic [7:0] a;
        case (c)
            8'h16:   a = 8'h31;
            8'h1e:   a = 8'h32;
            8'h26:   a = 8'h33;
            8'h25:   a = 8'h34;
            8'h2e:   a = 8'h35;
            8'h36:   a = 8'h36;
            8'h3d:   a = 8'h37;
            8'h3e:   a = 8'h38;
            8'h46:   a = 8'h39;
            8'h45:   a = 8'h30;
            8'h29:   a = 8'h20;
            default: a = 8'hff;
        endcase
        return a;
    endfunction

    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < COUNT_DIGITS; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // A break compares against the held key using the same {ext, code} match
    // that detects typematic repeats on a make.
    always_comb begin
        brk_state   = (state == BRK) || (state == EXT_BRK);
        ext_state   = (state == EXT) || (state == EXT_BRK);
        same_key    = key_held && ({ext_state, in_data} == {key_ext, key_code});
        make_now    = in_valid && !brk_state &&
                      (in_data != 8'hf0) && (in_data != 8'he0);
        release_now = in_valid && brk_state && same_key;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            timer       <= '0;
            key_held    <= 1'b0;
            key_ext     <= 1'b0;
            key_code    <= 8'h00;
            key_ascii   <= 8'hff;
            press_count <= '0;
        end else begin
            if (in_valid) begin
                timer <= '0;
                unique case (state)
                    IDLE, EXT: begin
                        if (in_data == 8'hf0)
                            state <= (state == EXT) ? EXT_BRK : BRK;
                        else if (in_data == 8'he0)
                            state <= EXT;
                        else
                            state <= IDLE;
                    end
                    BRK, EXT_BRK: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                timer <= '0;
            end else if (timer == TLAST) begin
                state <= IDLE;
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end

            if (make_now && !same_key) begin
                key_held    <= 1'b1;
                key_code    <= in_data;
                key_ext     <= ext_state;
                key_ascii   <= ext_state ? 8'hff : ascii_of(in_data);
                press_count <= bcd_inc(press_count);
            end
            if (release_now)
                key_held <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            seg_code  <= {BLANK, BLANK};
            seg_ascii <= {BLANK, BLANK};
            seg_count <= {COUNT_DIGITS{hex_seg(4'd0)}};
        end else begin
            seg_code <= key_held ?
                {hex_seg(key_code[7:4]), hex_seg(key_code[3:0])} :
                {BLANK, BLANK};
            seg_ascii <= (key_held && key_ascii != 8'hff) ?
                {hex_seg(key_ascii[7:4]), hex_seg(key_ascii[3:0])} :
                {BLANK, BLANK};
            for (int i = 0; i < COUNT_DIGITS; i++)
                seg_count[8*i +: 8] <= hex_seg(press_count[4*i +: 4]);
        end
    end

endmodule
